// File: rtl/nrs_pkg.sv
// Shared types and default sizing for the NRS ping-pong Gold-sequence buffer.
package nrs_pkg;

  localparam int NRS_WIDTH_REG = 16;
  localparam int NRS_N_RD      = 2;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ACTIVE    = 2'd1,
    ST_FULL_WAIT = 2'd2
  } nrs_state_t;

endpackage

// File: rtl/nrs_bank.sv
// One WIDTH_REG-bit sequence bank: single-bit indexed write, N_RD combinational pair reads.
module nrs_bank
  import nrs_pkg::*;
#(
  parameter int WIDTH_REG = NRS_WIDTH_REG,
  parameter int N_RD      = NRS_N_RD,
  parameter int AW        = $clog2(WIDTH_REG / 2)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic [$clog2(WIDTH_REG)-1:0] wr_idx,
  input  logic                         wr_bit,
  input  logic [N_RD*AW-1:0]           rd_addr,
  output logic [2*N_RD-1:0]            rd_pair
);

  logic [WIDTH_REG-1:0] bits;

  // Store one serial bit at its sequence index.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      bits <= '0;
    else if (wr_en)
      bits[wr_idx] <= wr_bit;
  end

  // Pair m is {c(2m+1), c(2m)}; the pair index shifted left by one is the bit index.
  always_comb begin
    rd_pair = '0;
    for (int k = 0; k < N_RD; k++)
      rd_pair[2*k +: 2] = bits[{rd_addr[k*AW +: AW], 1'b0} +: 2];
  end

endmodule

// File: rtl/nrs_pingpong_buf.sv
// Ping-pong buffer for a serial Gold sequence: one bank fills while the other is read
// as bit pairs by independent ports.
//
// state        | meaning
// -------------+---------------------------------------------------------
// ST_IDLE      | no valid read bank; writer filling
// ST_ACTIVE    | read bank holds a complete sequence; writer filling other bank
// ST_FULL_WAIT | both banks complete; reader still holds its bank, writes dropped
module nrs_pingpong_buf
  import nrs_pkg::*;
#(
  parameter int WIDTH_REG = NRS_WIDTH_REG,
  parameter int N_RD      = NRS_N_RD,
  parameter int AW        = $clog2(WIDTH_REG / 2)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_start,
  input  logic                 wr_valid,
  input  logic                 c_n,
  input  logic [N_RD-1:0]      rd_en,
  input  logic [N_RD*AW-1:0]   rd_addr,
  input  logic                 rd_release,
  output logic [2*N_RD-1:0]    rd_data,
  output logic [N_RD-1:0]      rd_valid,
  output logic                 bank_ready,
  output logic                 overflow
);

  localparam int PW = $clog2(WIDTH_REG);

  nrs_state_t          state;
  logic                bank_sel;   // read bank index; write bank is the other one
  logic [PW-1:0]       wr_ptr;
  logic [PW-1:0]       wr_idx;
  logic                drop;
  logic                wr_en;
  logic                wr_complete;
  logic [2*N_RD-1:0]   pair0;
  logic [2*N_RD-1:0]   pair1;
  logic [2*N_RD-1:0]   rd_pair;

  assign drop        = wr_valid && (state == ST_FULL_WAIT);
  assign wr_en       = wr_valid && !drop;
  assign wr_idx      = wr_start ? '0 : wr_ptr;
  // A restart write lands at index 0, so it can never complete a fill.
  assign wr_complete = wr_en && !wr_start && (wr_ptr == PW'(WIDTH_REG - 1));
  assign rd_pair     = bank_sel ? pair1 : pair0;

  nrs_bank #(.WIDTH_REG(WIDTH_REG), .N_RD(N_RD), .AW(AW)) u_bank0 (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en && bank_sel),
    .wr_idx  (wr_idx),
    .wr_bit  (c_n),
    .rd_addr (rd_addr),
    .rd_pair (pair0)
  );

  nrs_bank #(.WIDTH_REG(WIDTH_REG), .N_RD(N_RD), .AW(AW)) u_bank1 (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en && !bank_sel),
    .wr_idx  (wr_idx),
    .wr_bit  (c_n),
    .rd_addr (rd_addr),
    .rd_pair (pair1)
  );

  // Write pointer: restart discards the partial fill, wraps after the last bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      wr_ptr <= '0;
    else if (wr_start)
      wr_ptr <= wr_en ? PW'(1) : '0;
    else if (wr_en)
      wr_ptr <= wr_complete ? '0 : wr_ptr + PW'(1);
  end

  // Sticky drop flag; a restart wins over a drop in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      overflow <= 1'b0;
    else if (wr_start)
      overflow <= 1'b0;
    else if (drop)
      overflow <= 1'b1;
  end

  // Bank hand-over FSM with registered bank_ready.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      bank_sel   <= 1'b0;
      bank_ready <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (wr_complete) begin
            bank_sel   <= ~bank_sel;
            state      <= ST_ACTIVE;
            bank_ready <= 1'b1;
          end
        end
        ST_ACTIVE: begin
          if (wr_complete && rd_release) begin
            bank_sel <= ~bank_sel;
          end else if (wr_complete) begin
            state <= ST_FULL_WAIT;
          end else if (rd_release) begin
            state      <= ST_IDLE;
            bank_ready <= 1'b0;
          end
        end
        ST_FULL_WAIT: begin
          if (rd_release) begin
            bank_sel <= ~bank_sel;
            state    <= ST_ACTIVE;
          end
        end
        default: begin
          state      <= ST_IDLE;
          bank_ready <= 1'b0;
        end
      endcase
    end
  end

  // Per-port registered read; data forced to zero when no bank is valid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data  <= '0;
      rd_valid <= '0;
    end else begin
      for (int k = 0; k < N_RD; k++) begin
        if (rd_en[k]) begin
          rd_valid[k]       <= bank_ready;
          rd_data[2*k +: 2] <= bank_ready ? rd_pair[2*k +: 2] : 2'b00;
        end else begin
          rd_valid[k] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_nrs_pingpong_buf.sv
// Directed bench for nrs_pingpong_buf with a per-port read scoreboard.
module tb_nrs_pingpong_buf;

  localparam int WIDTH_REG = 16;
  localparam int N_RD      = 2;
  localparam int AW        = 3;

  logic               clk;
  logic               rst;
  logic               wr_start;
  logic               wr_valid;
  logic               c_n;
  logic [N_RD-1:0]    rd_en;
  logic [N_RD*AW-1:0] rd_addr;
  logic               rd_release;
  logic [2*N_RD-1:0]  rd_data;
  logic [N_RD-1:0]    rd_valid;
  logic               bank_ready;
  logic               overflow;

  int checks = 0;
  int errors = 0;

  logic [2:0] q0[$];
  logic [2:0] q1[$];
  logic [N_RD-1:0] rd_issued;

  nrs_pingpong_buf #(.WIDTH_REG(WIDTH_REG), .N_RD(N_RD), .AW(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_start   (wr_start),
    .wr_valid   (wr_valid),
    .c_n        (c_n),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_release (rd_release),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .bank_ready (bank_ready),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Write bits v[0..n-1] serially, one per cycle.
  task automatic fill_bits(input logic [15:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      wr_valid = 1'b1;
      c_n      = v[i];
      step();
    end
    wr_valid = 1'b0;
  endtask

  // Full fill; bank_ready must still be low before the last bit and high after it.
  task automatic fill_full(input logic [15:0] v, input string tag);
    fill_bits(v, 15);
    chk({tag, "_ready_before_last"}, 32'(bank_ready), 32'd0);
    fill_bits({15'd0, v[15]}, 1);
    chk({tag, "_ready_after_last"}, 32'(bank_ready), 32'd1);
  endtask

  // Issue reads on both ports for one cycle; expected {valid, data} go to the scoreboard.
  task automatic read2(input logic e0, input logic [2:0] a0, input logic [2:0] x0,
                       input logic e1, input logic [2:0] a1, input logic [2:0] x1);
    rd_en   = {e1, e0};
    rd_addr = {a1, a0};
    if (e0) q0.push_back(x0);
    if (e1) q1.push_back(x1);
    step();
    rd_en = '0;
  endtask

  // Track which ports were strobed on the last edge; response is due this cycle.
  always @(posedge clk or negedge rst) begin
    if (!rst) rd_issued <= '0;
    else      rd_issued <= rd_en;
  end

  task automatic mon_port(input int k, input logic issued, input logic [2:0] act);
    logic [2:0] exp;
    checks++;
    if (issued) begin
      if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
        errors++;
        $display("FAIL rd%0d_no_expect actual=%0h expected=none", k, act);
      end else begin
        exp = (k == 0) ? q0.pop_front() : q1.pop_front();
        if (act !== exp) begin
          errors++;
          $display("FAIL rd%0d_resp actual={v,d}=%0h expected=%0h", k, act, exp);
        end
      end
    end else if (act[2] !== 1'b0) begin
      errors++;
      $display("FAIL rd%0d_spurious_valid actual=%0b expected=0", k, act[2]);
    end
  endtask

  // Monitor: compare every port's output half a cycle after each edge.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      mon_port(0, rd_issued[0], {rd_valid[0], rd_data[1:0]});
      mon_port(1, rd_issued[1], {rd_valid[1], rd_data[3:2]});
    end
  end

  initial begin
    rst = 1'b0; wr_start = 1'b0; wr_valid = 1'b0; c_n = 1'b0;
    rd_en = '0; rd_addr = '0; rd_release = 1'b0;
    repeat (3) step();
    chk("reset_bank_ready", 32'(bank_ready), 32'd0);
    chk("reset_overflow", 32'(overflow), 32'd0);
    chk("reset_rd_valid", 32'(rd_valid), 32'd0);
    chk("reset_rd_data", 32'(rd_data), 32'd0);
    rst = 1'b1;
    step();

    // First fill 0xA5C3 -> ACTIVE, read bank = 0xA5C3
    fill_full(16'hA5C3, "fill1");
    read2(1'b1, 3'd0, 3'b1_11, 1'b1, 3'd2, 3'b1_00);
    read2(1'b1, 3'd7, 3'b1_10, 1'b1, 3'd1, 3'b1_00);

    // Second fill 0x0F0F without release -> FULL_WAIT, then drops
    fill_bits(16'h0F0F, 16);
    chk("fullwait_ready", 32'(bank_ready), 32'd1);
    chk("fullwait_no_ovf_yet", 32'(overflow), 32'd0);
    fill_bits(16'h0007, 3);
    chk("drop_overflow", 32'(overflow), 32'd1);
    read2(1'b1, 3'd0, 3'b1_11, 1'b1, 3'd1, 3'b1_00);
    wr_start = 1'b1; wr_valid = 1'b1; c_n = 1'b1;
    step();
    wr_start = 1'b0; wr_valid = 1'b0;
    chk("start_with_drop_clears_ovf", 32'(overflow), 32'd0);
    fill_bits(16'h0001, 1);
    chk("overflow_sticky_again", 32'(overflow), 32'd1);
    rd_release = 1'b1;
    step();
    rd_release = 1'b0;
    chk("release_ready_stays", 32'(bank_ready), 32'd1);
    read2(1'b1, 3'd0, 3'b1_11, 1'b1, 3'd1, 3'b1_11);

    // Write-complete coincident with release: toggle, stay ACTIVE, read sees old bank
    wr_start = 1'b1;
    step();
    wr_start = 1'b0;
    chk("wr_start_clears_ovf", 32'(overflow), 32'd0);
    fill_bits(16'h5555, 15);
    wr_valid = 1'b1; c_n = 1'b0; rd_release = 1'b1;
    read2(1'b1, 3'd1, 3'b1_11, 1'b1, 3'd0, 3'b1_11);
    wr_valid = 1'b0; rd_release = 1'b0;
    chk("coincident_ready", 32'(bank_ready), 32'd1);
    chk("coincident_no_ovf", 32'(overflow), 32'd0);
    read2(1'b1, 3'd1, 3'b1_01, 1'b1, 3'd7, 3'b1_01);

    // Release with no pending fill -> IDLE
    rd_release = 1'b1;
    step();
    rd_release = 1'b0;
    chk("release_to_idle_ready", 32'(bank_ready), 32'd0);
    read2(1'b1, 3'd1, 3'b0_00, 1'b1, 3'd7, 3'b0_00);

    // Partial fill, then restart with a bit; needs full 16 post-start bits
    fill_bits(16'h0000, 8);
    wr_start = 1'b1; wr_valid = 1'b1; c_n = 1'b1;
    step();
    wr_start = 1'b0; wr_valid = 1'b0;
    fill_bits(16'hFFFF, 14);
    chk("restart_ready_before_16th", 32'(bank_ready), 32'd0);
    fill_bits(16'h0001, 1);
    chk("restart_ready_after_16th", 32'(bank_ready), 32'd1);
    read2(1'b1, 3'd7, 3'b1_11, 1'b1, 3'd0, 3'b1_11);

    // Asynchronous reset in the middle of a fill while ACTIVE
    fill_bits(16'h001F, 5);
    read2(1'b1, 3'd7, 3'b1_11, 1'b0, 3'd0, 3'b0_00);
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("async_rst_bank_ready", 32'(bank_ready), 32'd0);
    chk("async_rst_overflow", 32'(overflow), 32'd0);
    chk("async_rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("async_rst_rd_data", 32'(rd_data), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    step();
    read2(1'b1, 3'd7, 3'b0_00, 1'b1, 3'd0, 3'b0_00);
    chk("post_rst_ready", 32'(bank_ready), 32'd0);
    fill_full(16'h1234, "post_rst_fill");
    read2(1'b1, 3'd2, 3'b1_11, 1'b1, 3'd0, 3'b1_00);

    repeat (3) step();
    chk("scoreboard_drained", 32'(q0.size() + q1.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/nrs_pingpong_buf.md
NRS_PINGPONG_BUF -- requirements
Module: nrs_pingpong_buf

Interface
Parameters (name, default, meaning):
REQ-001 WIDTH_REG, 16, bits per bank (even, power of 2).
REQ-002 N_RD, 2, independent read ports (port 0 = channel estimation, port 1 = fine timing).
REQ-003 AW, $clog2(WIDTH_REG/2), pair-address width.
Ports (name, direction, width, meaning):
REQ-004 clk  in  1  clock.
REQ-005 rst  in  1  reset, asynchronous, active-low.
REQ-006 wr_start  in  1  restart write pointer, clear overflow.
REQ-007 wr_valid  in  1  c_n is a valid serial Gold-sequence bit.
REQ-008 c_n  in  1  serial bit, c(0) first.
REQ-009 rd_en  in  N_RD  per-port read strobe.
REQ-010 rd_addr  in  N_RD*AW  per-port pair index m, port k in slice [k*AW +: AW].
REQ-011 rd_release  in  1  reader has finished with the current read bank.
REQ-012 rd_data  out  2*N_RD  per-port pair {c(2m+1), c(2m)}, port k in slice [2k +: 2].
REQ-013 rd_valid  out  N_RD  per-port data-valid.
REQ-014 bank_ready  out  1  read bank holds a complete sequence.
REQ-015 overflow  out  1  sticky: a bit was dropped.

Function
REQ-016 Two banks of WIDTH_REG bits: one is the write bank, the other the read bank; bank_sel selects which.
REQ-017 On wr_valid, if not dropped, write c_n to write-bank[wr_ptr] and increment wr_ptr; wr_ptr wraps from WIDTH_REG-1 to 0; the write that wraps it is the write-complete event.
REQ-018 wr_start sets wr_ptr to 0 and discards any partial fill; if wr_valid is also asserted, write the bit at index 0 and set wr_ptr to 1.
REQ-019 FSM states: IDLE (no valid read bank), ACTIVE (read bank valid), FULL_WAIT (write bank complete, read bank still held).
REQ-020 IDLE: on write-complete, toggle bank_sel and go to ACTIVE.
REQ-021 ACTIVE: write-complete without rd_release goes to FULL_WAIT; write-complete with rd_release in the same cycle toggles bank_sel and stays in ACTIVE; rd_release alone goes to IDLE.
REQ-022 FULL_WAIT: wr_valid is dropped and sets overflow; rd_release toggles bank_sel and goes to ACTIVE.
REQ-023 bank_ready is registered and equals 1 exactly in ACTIVE and FULL_WAIT.
REQ-024 It rises on the edge after the 16th bit is written (WIDTH_REG=16).
REQ-025 Read latency is 1 cycle; registered per port.
REQ-026 If rd_en[k]=1, rd_data[k] is loaded with read-bank bits {2m+1, 2m} of that cycle's read bank, and rd_valid[k] is set to bank_ready.
REQ-027 If rd_en[k]=0, rd_valid[k] is cleared and rd_data[k] holds its value.
REQ-028 A read in IDLE returns rd_valid=0 with the data forced to 2'b00.
REQ-029 A read in the same cycle as a bank toggle returns the pre-toggle read bank.
REQ-030 Ports are fully independent; equal addresses on all ports are legal.
REQ-031 overflow is sticky and is cleared only by wr_start or reset; a wr_start in the same cycle as a drop leaves overflow cleared.

Reset
REQ-032 rst low asynchronously clears both banks, wr_ptr, bank_sel, rd_data, rd_valid, bank_ready and overflow to 0, and forces the FSM to IDLE.
REQ-033 Reset in the middle of a fill discards the partial fill.
REQ-034 After reset is released, the first bank_ready requires a full WIDTH_REG-bit fill.

Structure
REQ-035 Shared package nrs_pkg SHALL hold the FSM state enum and the default WIDTH_REG/N_RD constants.
REQ-036 Sub-module nrs_bank (one WIDTH_REG-bit register with write enable, write index and combinational pair read) SHALL be instantiated twice.

Verification (WIDTH_REG=16, N_RD=2)
REQ-037 Fill with 0xA5C3, LSB first, 16 cycles -> bank_ready=1 on the next edge; read port0 m=0 -> 2'b11, port1 m=2 -> 2'b00, both rd_valid=1 one cycle later.
REQ-038 A second fill of 0x0F0F while ACTIVE with no release -> FULL_WAIT; 3 more wr_valid -> overflow=1, port0 m=0 still returns 2'b11; rd_release -> m=0 returns 2'b11 from 0x0F0F, bank_ready stays 1.
REQ-039 Write-complete and rd_release in the same cycle -> bank toggles, state stays ACTIVE, no overflow, the read in that cycle returns old-bank data.
REQ-040 8 bits written, then wr_start, then 16 bits of 0xFFFF -> bank_ready rises only after the 16th post-start bit; m=7 -> 2'b11.
REQ-041 rst asserted mid-fill while ACTIVE -> all outputs 0 asynchronously; a read after release gives rd_valid=0 and data 2'b00.
REQ-042 rd_release in ACTIVE with no pending fill -> IDLE, bank_ready=0 on the next edge, subsequent reads give rd_valid=0.
